tlu_dut_rx: RTL and testbench
=============================

Name: tlu_dut_rx

Overview:
- DUT-side end of the TLU trigger handshake: detects TLU_TRIGGER, asserts TLU_BUSY, generates TLU_CLOCK and shifts in the trigger ID serialised by the master's transmitter.
- Presents each received ID on a valid/ready output.
- Holds TLU_BUSY for backpressure until the ID is consumed and the DUT is ready.
- Sits in DUT/test firmware and in loopback benches of the TLU master.

Parameters:
- MAX_ID_BITS, 31, width of TRIGGER_ID; N_BITS_TRIGGER_ID is clamped to this value.

Ports:
- BUS_CLK  in  1  clock; all logic in this domain.
- RST  in  1  synchronous reset, active-high.
- ENABLE  in  1  accept triggers when high.
- N_BITS_TRIGGER_ID  in  5  ID bits to clock in; 0 = trigger-only handshake.
- CLK_DIV  in  8  TLU_CLOCK half-period in BUS_CLK cycles; values below 4 are treated as 4.
- CONF_TIME_OUT  in  16  max cycles waiting for TLU_TRIGGER to fall after BUSY is raised.
- HOLD_BUSY  in  1  DUT busy; extends TLU_BUSY.
- TLU_TRIGGER  in  1  asynchronous trigger/data line from master.
- TLU_RESET  in  1  asynchronous reset line from master.
- TLU_BUSY  out  1  busy to master.
- TLU_CLOCK  out  1  shift clock to master.
- TRIGGER_ID  out  MAX_ID_BITS  received ID, LSB first on wire, zero-extended.
- ID_VALID  out  1  TRIGGER_ID valid.
- ID_READY  in  1  consumer accepts when ID_VALID & ID_READY.
- TLU_RESET_PULSE  out  1  one-cycle pulse on synchronised TLU_RESET rising edge.
- TRIG_CNT  out  32  completed handshakes, wraps.
- TIMEOUT_CNT  out  8  aborted handshakes, saturates at 0xFF.

Behaviour:
- Input synchronisation: TLU_TRIGGER and TLU_RESET each pass a 2-FF synchroniser. Decisions use the synchronised values (trg_s, rst_s).
- Reset: all outputs 0, FSM in IDLE, counters 0.
- IDLE
  - Leave on trg_s rising edge with ENABLE=1.
  - Latch n = min(N_BITS_TRIGGER_ID, MAX_ID_BITS) and div = max(CLK_DIV, 4).
  - Clear the shift register and raise TLU_BUSY on the next cycle.
  - Go to WAIT_TRIG_LOW.
  - ENABLE=0 or trg_s level without an edge: stay in IDLE.
- WAIT_TRIG_LOW
  - Count cycles.
  - trg_s=0: go to SHIFT_HI if n>0, else DONE.
  - Count reaches CONF_TIME_OUT with trg_s still 1: go to ABORT and increment TIMEOUT_CNT (saturating).
- SHIFT_HI
  - TLU_CLOCK=1 for div cycles.
  - On the last cycle sample trg_s into bit position k (k=0 first), then go to SHIFT_LO.
- SHIFT_LO
  - TLU_CLOCK=0 for div cycles.
  - Increment k; if k==n go to DONE, else go to SHIFT_HI.
- DONE
  - TRIGGER_ID <= shift register; bits >= n are 0.
  - ID_VALID=1, TRIG_CNT+1, go to WAIT_ACCEPT.
- WAIT_ACCEPT
  - ID_VALID and TRIGGER_ID held stable until ID_READY.
  - On acceptance ID_VALID drops next cycle.
  - TLU_BUSY stays high until accepted and HOLD_BUSY=0, then drops; go to IDLE.
  - Min busy-to-idle: 1 cycle after both conditions are met.
- ABORT
  - TLU_BUSY=0, TLU_CLOCK=0.
  - Wait for trg_s=0, then go to IDLE. No ID is produced.
- TLU_CLOCK is 0 in all states except SHIFT_HI. TLU_BUSY is 1 in WAIT_TRIG_LOW through WAIT_ACCEPT.
- TLU_RESET
  - rst_s rising edge produces TLU_RESET_PULSE for 1 cycle and clears TRIG_CNT.
  - Does not abort the FSM. If DONE coincides with the edge, the clear wins and TRIG_CNT = 0.
- Changing config inputs mid-handshake has no effect; values are latched in IDLE.
- RST mid-handshake: immediate return to IDLE, BUSY/CLOCK low, pending ID discarded.

Optional Feature:
- Macro: TLU_DUT_RX_TIMESTAMP_EN.
- Defined:
  - Adds a free-running 32-bit counter (reset 0, wraps) and output TIMESTAMP[31:0].
  - The counter value is latched at IDLE exit (trigger edge detection).
  - TIMESTAMP is presented and held together with TRIGGER_ID while ID_VALID.
- Undefined: no counter, no TIMESTAMP port.

Test Plan:
- Basic ID: N_BITS=15, CLK_DIV=4, master sends ID 0x1234 LSB first.
  - Exactly 15 TLU_CLOCK pulses, each 4 high/4 low.
  - TRIGGER_ID=0x1234, ID_VALID=1, TRIG_CNT=1.
  - BUSY drops 1 cycle after ID_READY.
- Backpressure: ID_READY=0 for 100 cycles, then HOLD_BUSY=1 for 20 more.
  - ID_VALID held.
  - BUSY stays high until both are released.
  - A second TLU_TRIGGER edge during this time is ignored.
- Timeout: CONF_TIME_OUT=50, TLU_TRIGGER held high for 200 cycles.
  - BUSY drops after ~50 cycles, TIMEOUT_CNT=1, no ID_VALID.
  - Next valid trigger only after TLU_TRIGGER returns low.
  - 300 forced timeouts leave TIMEOUT_CNT=0xFF.
- Edge configs:
  - N_BITS=0: BUSY handshake only, TLU_CLOCK never toggles, TRIGGER_ID=0.
  - N_BITS=31, ID 0x7FFFFFFF: all ones.
  - CLK_DIV=1: half-period of 4 cycles.
  - ENABLE=0: no BUSY.
- TLU_RESET pulse after 5 triggers: one-cycle TLU_RESET_PULSE, TRIG_CNT=0. A handshake in progress completes normally, after which TRIG_CNT=1.
- RST asserted during SHIFT_HI: BUSY and CLOCK are 0 the next cycle and ID_VALID never asserts. A following trigger with ID 0x0005 is received correctly.

Source files
------------

// File: rtl/tlu_dut_rx.sv
// DUT-side receiver for the TLU trigger handshake: BUSY/CLOCK generation and LSB-first ID capture.
// Optional feature macro: TLU_DUT_RX_TIMESTAMP_EN adds a free-running counter latched per trigger.
module tlu_dut_rx #(
    parameter int MAX_ID_BITS = 31
) (
    input  logic                   BUS_CLK,
    input  logic                   RST,
    input  logic                   ENABLE,
    input  logic [4:0]             N_BITS_TRIGGER_ID,
    input  logic [7:0]             CLK_DIV,
    input  logic [15:0]            CONF_TIME_OUT,
    input  logic                   HOLD_BUSY,
    input  logic                   TLU_TRIGGER,
    input  logic                   TLU_RESET,
    output logic                   TLU_BUSY,
    output logic                   TLU_CLOCK,
    output logic [MAX_ID_BITS-1:0] TRIGGER_ID,
    output logic                   ID_VALID,
    input  logic                   ID_READY,
    output logic                   TLU_RESET_PULSE,
    output logic [31:0]            TRIG_CNT,
    output logic [7:0]             TIMEOUT_CNT
`ifdef TLU_DUT_RX_TIMESTAMP_EN
    ,
    output logic [31:0]            TIMESTAMP
`endif
);

    localparam logic [2:0] S_IDLE          = 3'd0;
    localparam logic [2:0] S_WAIT_TRIG_LOW = 3'd1;
    localparam logic [2:0] S_SHIFT_HI      = 3'd2;
    localparam logic [2:0] S_SHIFT_LO      = 3'd3;
    localparam logic [2:0] S_DONE          = 3'd4;
    localparam logic [2:0] S_WAIT_ACCEPT   = 3'd5;
    localparam logic [2:0] S_ABORT         = 3'd6;

    localparam logic [4:0] N_MAX   = (MAX_ID_BITS >= 31) ? 5'd31 : 5'(MAX_ID_BITS);
    localparam logic [7:0] DIV_MIN = 8'd4;

    logic [2:0]             state;
    logic [2:0]             state_nxt;
    logic                   trg_meta;
    logic                   trg_s;
    logic                   trg_d;
    logic                   rst_meta;
    logic                   rst_s;
    logic                   rst_d;
    logic                   trg_rise;
    logic                   rst_rise;
    logic [5:0]             n_lat;
    logic [7:0]             div_lat;
    logic [15:0]            tout_lat;
    logic [15:0]            wait_cnt;
    logic [7:0]             phase;
    logic [5:0]             bit_idx;
    logic [MAX_ID_BITS-1:0] shift_reg;
    logic                   accepted;
    logic                   handshake;
    logic                   phase_last;
    logic                   last_bit;
    logic [4:0]             n_clamped;
    logic [7:0]             div_clamped;

    // Two-flop synchronisers plus one history flop each for edge detection.
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            trg_meta <= 1'b0;
            trg_s    <= 1'b0;
            trg_d    <= 1'b0;
            rst_meta <= 1'b0;
            rst_s    <= 1'b0;
            rst_d    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbour.
            trg_meta <= TLU_TRIGGER;
            trg_s    <= trg_meta;
            trg_d    <= trg_s;
            rst_meta <= TLU_RESET;
            rst_s    <= rst_meta;
            rst_d    <= rst_s;
        end
    end

    assign trg_rise    = trg_s & ~trg_d;
    assign rst_rise    = rst_s & ~rst_d;
    assign handshake   = ID_VALID & ID_READY;
    assign phase_last  = (phase == div_lat - 8'd1);
    assign last_bit    = (bit_idx + 6'd1 == n_lat);
    assign n_clamped   = (N_BITS_TRIGGER_ID > N_MAX) ? N_MAX : N_BITS_TRIGGER_ID;
    assign div_clamped = (CLK_DIV < DIV_MIN) ? DIV_MIN : CLK_DIV;

    always_comb begin
        // NOTE: default assignment first keeps this block free of inferred latches.
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (trg_rise && ENABLE) state_nxt = S_WAIT_TRIG_LOW;
            end
            S_WAIT_TRIG_LOW: begin
                if (!trg_s)                    state_nxt = (n_lat != 6'd0) ? S_SHIFT_HI : S_DONE;
                else if (wait_cnt >= tout_lat) state_nxt = S_ABORT;
            end
            S_SHIFT_HI: begin
                if (phase_last) state_nxt = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                if (phase_last) state_nxt = last_bit ? S_DONE : S_SHIFT_HI;
            end
            S_DONE: begin
                state_nxt = S_WAIT_ACCEPT;
            end
            S_WAIT_ACCEPT: begin
                if ((accepted || handshake) && !HOLD_BUSY) state_nxt = S_IDLE;
            end
            S_ABORT: begin
                if (!trg_s) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // BUSY and CLOCK are registered from the next state so the wires to the master never glitch.
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            TLU_BUSY  <= 1'b0;
            TLU_CLOCK <= 1'b0;
        end else begin
            state     <= state_nxt;
            TLU_BUSY  <= (state_nxt == S_WAIT_TRIG_LOW) || (state_nxt == S_SHIFT_HI) ||
                         (state_nxt == S_SHIFT_LO) || (state_nxt == S_DONE) ||
                         (state_nxt == S_WAIT_ACCEPT);
            TLU_CLOCK <= (state_nxt == S_SHIFT_HI);
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            n_lat       <= '0;
            div_lat     <= DIV_MIN;
            tout_lat    <= '0;
            wait_cnt    <= '0;
            phase       <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            accepted    <= 1'b0;
            TRIGGER_ID  <= '0;
            ID_VALID    <= 1'b0;
            TIMEOUT_CNT <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (state_nxt == S_WAIT_TRIG_LOW) begin
                        n_lat     <= {1'b0, n_clamped};
                        div_lat   <= div_clamped;
                        tout_lat  <= CONF_TIME_OUT;
                        wait_cnt  <= '0;
                        phase     <= '0;
                        bit_idx   <= '0;
                        shift_reg <= '0;
                        accepted  <= 1'b0;
                    end
                end
                S_WAIT_TRIG_LOW: begin
                    wait_cnt <= wait_cnt + 16'd1;
                    if (state_nxt == S_ABORT && TIMEOUT_CNT != 8'hFF)
                        TIMEOUT_CNT <= TIMEOUT_CNT + 8'd1;
                end
                S_SHIFT_HI: begin
                    if (phase_last) begin
                        phase <= '0;
                        for (int i = 0; i < MAX_ID_BITS; i++) begin
                            if (bit_idx == 6'(i)) shift_reg[i] <= trg_s;
                        end
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                S_SHIFT_LO: begin
                    if (phase_last) begin
                        phase   <= '0;
                        bit_idx <= bit_idx + 6'd1;
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                S_DONE: begin
                    TRIGGER_ID <= shift_reg;
                    ID_VALID   <= 1'b1;
                end
                S_WAIT_ACCEPT: begin
                    if (handshake) begin
                        ID_VALID <= 1'b0;
                        accepted <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // A master reset edge clears the handshake count even when it lands on the DONE cycle.
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            TRIG_CNT        <= '0;
            TLU_RESET_PULSE <= 1'b0;
        end else begin
            TLU_RESET_PULSE <= rst_rise;
            if (rst_rise)             TRIG_CNT <= '0;
            else if (state == S_DONE) TRIG_CNT <= TRIG_CNT + 32'd1;
        end
    end

`ifdef TLU_DUT_RX_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] ts_lat;

    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            ts_cnt    <= '0;
            ts_lat    <= '0;
            TIMESTAMP <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (state == S_IDLE && state_nxt == S_WAIT_TRIG_LOW) ts_lat <= ts_cnt;
            if (state == S_DONE) TIMESTAMP <= ts_lat;
        end
    end
`endif

endmodule

// File: tb/tb_tlu_dut_rx.sv
// Bench for tlu_dut_rx: a behavioural TLU master drives directed IDs; a monitor checks presented IDs.
module tb_tlu_dut_rx;

    logic        BUS_CLK;
    logic        RST;
    logic        ENABLE;
    logic [4:0]  N_BITS_TRIGGER_ID;
    logic [7:0]  CLK_DIV;
    logic [15:0] CONF_TIME_OUT;
    logic        HOLD_BUSY;
    logic        TLU_TRIGGER;
    logic        TLU_RESET;
    logic        TLU_BUSY;
    logic        TLU_CLOCK;
    logic [30:0] TRIGGER_ID;
    logic        ID_VALID;
    logic        ID_READY;
    logic        TLU_RESET_PULSE;
    logic [31:0] TRIG_CNT;
    logic [7:0]  TIMEOUT_CNT;
`ifdef TLU_DUT_RX_TIMESTAMP_EN
    logic [31:0] TIMESTAMP;
`endif

    tlu_dut_rx #(.MAX_ID_BITS(31)) dut (
        .BUS_CLK           (BUS_CLK),
        .RST               (RST),
        .ENABLE            (ENABLE),
        .N_BITS_TRIGGER_ID (N_BITS_TRIGGER_ID),
        .CLK_DIV           (CLK_DIV),
        .CONF_TIME_OUT     (CONF_TIME_OUT),
        .HOLD_BUSY         (HOLD_BUSY),
        .TLU_TRIGGER       (TLU_TRIGGER),
        .TLU_RESET         (TLU_RESET),
        .TLU_BUSY          (TLU_BUSY),
        .TLU_CLOCK         (TLU_CLOCK),
        .TRIGGER_ID        (TRIGGER_ID),
        .ID_VALID          (ID_VALID),
        .ID_READY          (ID_READY),
        .TLU_RESET_PULSE   (TLU_RESET_PULSE),
        .TRIG_CNT          (TRIG_CNT),
        .TIMEOUT_CNT       (TIMEOUT_CNT)
`ifdef TLU_DUT_RX_TIMESTAMP_EN
        ,
        .TIMESTAMP         (TIMESTAMP)
`endif
    );

    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    typedef struct {
        logic [30:0] id;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] exp_cnt;
    int          checks;
    int          errors;
    int          pulse_cycles;
    logic        valid_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per rising ID_VALID.
    always @(negedge BUS_CLK) begin
        if (TLU_RESET_PULSE) pulse_cycles++;
        if (ID_VALID && !valid_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_id: got id 0x%0h with nothing expected at %0t", TRIGGER_ID, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("trigger_id", 64'(TRIGGER_ID), 64'(mon_e.id));
                check("trig_cnt", 64'(TRIG_CNT), 64'(mon_e.cnt));
            end
        end
        valid_q = ID_VALID;
    end

    task automatic wait_busy(input string name);
        int guard = 0;
        while (!TLU_BUSY && guard < 20) begin
            @(negedge BUS_CLK);
            guard++;
        end
        check(name, 64'(TLU_BUSY), 64'd1);
    endtask

    // Behavioural master: raises the trigger, then drives bit k on each TLU_CLOCK rise.
    task automatic send_id(input logic [31:0] id, input int nbits, input int div_cfg,
                           input int exp_div, input bit mid_change, input int reset_bit);
        logic [30:0] mask;
        int          hi;
        int          lo;
        int          guard;
        int          pulses;
        int          extra;
        bit          hi_ok;
        bit          lo_ok;
        mask = '1;
        mask = (nbits == 0) ? 31'd0 : (mask >> (31 - nbits));
        if (reset_bit >= 0) exp_cnt = 0;
        exp_cnt = exp_cnt + 1;
        exp_q.push_back('{id: id[30:0] & mask, cnt: exp_cnt});
        N_BITS_TRIGGER_ID = 5'(nbits);
        CLK_DIV = 8'(div_cfg);
        @(negedge BUS_CLK);
        TLU_TRIGGER = 1'b1;
        wait_busy("busy_raise");
        TLU_TRIGGER = 1'b0;
        if (mid_change) begin
            CLK_DIV = 8'd9;
            N_BITS_TRIGGER_ID = 5'd2;
        end
        hi_ok = 1'b1;
        lo_ok = 1'b1;
        pulses = 0;
        for (int k = 0; k < nbits; k++) begin
            lo = 0;
            guard = 0;
            while (!TLU_CLOCK && guard < 200) begin
                @(negedge BUS_CLK);
                lo++;
                guard++;
            end
            if (!TLU_CLOCK) break;
            if (k > 0 && lo != exp_div) lo_ok = 1'b0;
            TLU_TRIGGER = id[k];
            if (reset_bit >= 0 && k == reset_bit) TLU_RESET = 1'b1;
            if (reset_bit >= 0 && k == reset_bit + 1) TLU_RESET = 1'b0;
            hi = 0;
            guard = 0;
            while (TLU_CLOCK && guard < 200) begin
                @(negedge BUS_CLK);
                hi++;
                guard++;
            end
            if (hi != exp_div) hi_ok = 1'b0;
            pulses++;
        end
        TLU_TRIGGER = 1'b0;
        TLU_RESET = 1'b0;
        if (reset_bit >= 0) check("trig_cnt_cleared", 64'(TRIG_CNT), 64'd0);
        guard = 0;
        extra = 0;
        while (!ID_VALID && guard < 100) begin
            @(negedge BUS_CLK);
            if (TLU_CLOCK) extra++;
            guard++;
        end
        check("id_valid_seen", 64'(ID_VALID), 64'd1);
        check("clock_pulses", 64'(pulses + extra), 64'(nbits));
        if (nbits > 0) check("clk_hi_width", 64'(hi_ok), 64'd1);
        if (nbits > 1) check("clk_lo_width", 64'(lo_ok), 64'd1);
        check("busy_while_valid", 64'(TLU_BUSY), 64'd1);
    endtask

    task automatic accept_id();
        ID_READY = 1'b1;
        @(negedge BUS_CLK);
        ID_READY = 1'b0;
        check("valid_drop", 64'(ID_VALID), 64'd0);
        check("busy_drop", 64'(TLU_BUSY), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  busy_len;
        bit  v_drop;
        bit  b_drop;
        int  guard;
        checks = 0;
        errors = 0;
        pulse_cycles = 0;
        valid_q = 1'b0;
        exp_cnt = 0;
        RST = 1'b1;
        ENABLE = 1'b1;
        N_BITS_TRIGGER_ID = 5'd15;
        CLK_DIV = 8'd4;
        CONF_TIME_OUT = 16'd1000;
        HOLD_BUSY = 1'b0;
        TLU_TRIGGER = 1'b0;
        TLU_RESET = 1'b0;
        ID_READY = 1'b0;
        repeat (5) @(negedge BUS_CLK);
        RST = 1'b0;
        @(negedge BUS_CLK);

        check("rst_busy", 64'(TLU_BUSY), 64'd0);
        check("rst_clock", 64'(TLU_CLOCK), 64'd0);
        check("rst_valid", 64'(ID_VALID), 64'd0);
        check("rst_id", 64'(TRIGGER_ID), 64'd0);
        check("rst_trig_cnt", 64'(TRIG_CNT), 64'd0);
        check("rst_timeout_cnt", 64'(TIMEOUT_CNT), 64'd0);

        // Basic 15-bit ID.
        send_id(32'h1234, 15, 4, 4, 1'b0, -1);
        accept_id();

        // Backpressure with a second trigger edge that must be ignored.
        send_id(32'hABC, 12, 4, 4, 1'b0, -1);
        v_drop = 1'b0;
        b_drop = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge BUS_CLK);
            if (c == 40) TLU_TRIGGER = 1'b1;
            if (c == 50) TLU_TRIGGER = 1'b0;
            if (!ID_VALID) v_drop = 1'b1;
            if (!TLU_BUSY) b_drop = 1'b1;
        end
        check("bp_valid_held", 64'(v_drop), 64'd0);
        check("bp_busy_held", 64'(b_drop), 64'd0);
        check("bp_id_held", 64'(TRIGGER_ID), 64'hABC);
        HOLD_BUSY = 1'b1;
        ID_READY = 1'b1;
        @(negedge BUS_CLK);
        ID_READY = 1'b0;
        check("bp_valid_drop", 64'(ID_VALID), 64'd0);
        b_drop = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge BUS_CLK);
            if (!TLU_BUSY) b_drop = 1'b1;
        end
        check("hold_busy_held", 64'(b_drop), 64'd0);
        HOLD_BUSY = 1'b0;
        @(negedge BUS_CLK);
        check("hold_busy_release", 64'(TLU_BUSY), 64'd0);
        repeat (10) @(negedge BUS_CLK);
        check("bp_trig_cnt", 64'(TRIG_CNT), 64'd2);

        // Timeout with the trigger stuck high.
        CONF_TIME_OUT = 16'd50;
        TLU_TRIGGER = 1'b1;
        busy_len = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge BUS_CLK);
            if (TLU_BUSY) busy_len++;
        end
        check("timeout_busy_len", 64'(busy_len >= 49 && busy_len <= 53), 64'd1);
        check("abort_busy_low", 64'(TLU_BUSY), 64'd0);
        check("timeout_cnt_one", 64'(TIMEOUT_CNT), 64'd1);
        TLU_TRIGGER = 1'b0;
        repeat (5) @(negedge BUS_CLK);

        // Saturation of the timeout counter.
        CONF_TIME_OUT = 16'd2;
        for (int a = 0; a < 299; a++) begin
            TLU_TRIGGER = 1'b1;
            repeat (10) @(negedge BUS_CLK);
            TLU_TRIGGER = 1'b0;
            repeat (5) @(negedge BUS_CLK);
        end
        check("timeout_cnt_sat", 64'(TIMEOUT_CNT), 64'hFF);
        CONF_TIME_OUT = 16'd1000;

        // Trigger-only handshake.
        send_id(32'h1F, 0, 4, 4, 1'b0, -1);
        accept_id();

        // Full-width all-ones ID.
        send_id(32'h7FFFFFFF, 31, 4, 4, 1'b0, -1);
        accept_id();

        // CLK_DIV below minimum, config changed mid-handshake.
        send_id(32'h9, 4, 1, 4, 1'b1, -1);
        accept_id();

        // ENABLE low: no handshake.
        ENABLE = 1'b0;
        TLU_TRIGGER = 1'b1;
        b_drop = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge BUS_CLK);
            if (TLU_BUSY) b_drop = 1'b1;
        end
        check("disabled_no_busy", 64'(b_drop), 64'd0);
        TLU_TRIGGER = 1'b0;
        repeat (5) @(negedge BUS_CLK);
        ENABLE = 1'b1;
        check("trig_cnt_five", 64'(TRIG_CNT), 64'd5);

        // TLU_RESET during a handshake.
        pulse_cycles = 0;
        send_id(32'hA5, 8, 4, 4, 1'b0, 2);
        check("reset_pulse_width", 64'(pulse_cycles), 64'd1);
        accept_id();

        // RST during SHIFT_HI, then a clean receive.
        N_BITS_TRIGGER_ID = 5'd16;
        CLK_DIV = 8'd4;
        TLU_TRIGGER = 1'b1;
        wait_busy("busy_before_rst");
        TLU_TRIGGER = 1'b0;
        guard = 0;
        while (!TLU_CLOCK && guard < 50) begin
            @(negedge BUS_CLK);
            guard++;
        end
        check("reached_shift_hi", 64'(TLU_CLOCK), 64'd1);
        RST = 1'b1;
        @(negedge BUS_CLK);
        check("rst_mid_busy", 64'(TLU_BUSY), 64'd0);
        check("rst_mid_clock", 64'(TLU_CLOCK), 64'd0);
        RST = 1'b0;
        exp_cnt = 0;
        repeat (30) @(negedge BUS_CLK);
        check("rst_mid_no_valid", 64'(ID_VALID), 64'd0);
        send_id(32'h0005, 16, 4, 4, 1'b0, -1);
        accept_id();

        repeat (5) @(negedge BUS_CLK);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
